// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready buffer placed between two pipeline stages. It holds up to DEPTH payloads in order.
// It adds a flush that kills everything held and reports its occupancy.
module pipe_stage_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full;
    logic              push;
    logic              pop;

    // Ready comes only from the registered count, so there is no combinational out_ready_i -> in_ready_o path.
    assign full        = (count_q == CNT_W'(DEPTH));
    assign in_ready_o  = ~full;
    assign out_valid_o = (count_q != '0) & ~flush_i;
    assign out_data_o  = mem_q[rdPtr_q];
    assign count_o     = count_q;

    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Payload storage is deliberately left unreset. Only the entries between rd and wr are meaningful.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_q[wrPtr_q] <= in_data_i;
        end
    end

    assertCountBound: assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= CNT_W'(DEPTH));

    assertNoWriteFull: assert property (@(posedge clk_i) disable iff (rst_i)
        push |-> !full);

    assertHeadStable: assert property (@(posedge clk_i)
        (!rst_i && out_valid_o && !out_ready_i && !flush_i) |=> $stable(out_data_o));

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised scoreboard bench for pipe_stage_buf. Two instances (DEPTH=2 and DEPTH=4) share stimulus.
// Each instance is checked against its own queue model.
module tb_pipe_stage_buf;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              inValid;
    logic [DATA_W-1:0] inData;
    logic              outReady;

    logic              inReadyA, outValidA;
    logic [DATA_W-1:0] outDataA;
    logic [1:0]        countA;
    logic              inReadyB, outValidB;
    logic [DATA_W-1:0] outDataB;
    logic [2:0]        countB;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] qA[$];
    logic [DATA_W-1:0] qB[$];

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DATA_W), .DEPTH(2)) dutA (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(inValid), .in_ready_o(inReadyA), .in_data_i(inData),
        .out_valid_o(outValidA), .out_ready_i(outReady), .out_data_o(outDataA),
        .count_o(countA)
    );

    pipe_stage_buf #(.DATA_W(DATA_W), .DEPTH(4)) dutB (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(inValid), .in_ready_o(inReadyB), .in_data_i(inData),
        .out_valid_o(outValidB), .out_ready_i(outReady), .out_data_o(outDataB),
        .count_o(countB)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic v,
                                 input logic [DATA_W-1:0] d, input logic rdy);
        rst      = r;
        flush    = f;
        inValid  = v;
        inData   = d;
        outReady = rdy;
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle monitor: compare against the queue models, then apply the upcoming edge's effect to them.
    always @(negedge clk) begin
        logic expReadyA, expValidA, expReadyB, expValidB;
        expReadyA = (qA.size() != 2);
        expValidA = (qA.size() != 0) && !flush;
        expReadyB = (qB.size() != 4);
        expValidB = (qB.size() != 0) && !flush;

        checkOutput("A.in_ready", 64'(inReadyA), 64'(expReadyA));
        checkOutput("A.out_valid", 64'(outValidA), 64'(expValidA));
        checkOutput("A.count", 64'(countA), 64'(qA.size()));
        checkOutput("B.in_ready", 64'(inReadyB), 64'(expReadyB));
        checkOutput("B.out_valid", 64'(outValidB), 64'(expValidB));
        checkOutput("B.count", 64'(countB), 64'(qB.size()));

        if (rst || flush) begin
            qA.delete();
            qB.delete();
        end else begin
            if (expValidA && outReady) begin
                checkOutput("A.out_data", outDataA, qA[0]);
                void'(qA.pop_front());
            end
            if (inValid && expReadyA) qA.push_back(inData);
            if (expValidB && outReady) begin
                checkOutput("B.out_data", outDataB, qB[0]);
                void'(qB.pop_front());
            end
            if (inValid && expReadyB) qB.push_back(inData);
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b0;

        // Reset held two cycles, then idle
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Fill with the sink stalled, attempt an overfill, then drain
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 64'hA0 + 64'(i), 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1);

        // Back-to-back streaming across several pointer wraps
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 64'h100 + 64'(i), 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1);

        // Full plus pop: the offered payload waits one cycle in the DEPTH=2 instance
        applyStimulus(0, 0, 1, 64'h11, 0);
        applyStimulus(0, 0, 1, 64'h22, 0);
        applyStimulus(0, 0, 1, 64'h33, 1);
        applyStimulus(0, 0, 1, 64'h33, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1);

        // Flush mid-stream with a same-cycle push and pop attempt
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 64'hC0 + 64'(i), 0);
        applyStimulus(0, 1, 1, 64'h99, 1);
        applyStimulus(0, 1, 1, 64'h98, 1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 64'h55, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);

        // Reset takes priority over flush and a pending push
        applyStimulus(0, 0, 1, 64'hE0, 0);
        applyStimulus(0, 0, 1, 64'hE1, 0);
        applyStimulus(1, 1, 1, 64'hE2, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);

        // Randomised traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 9) < 7),
                          {$urandom, $urandom},
                          ($urandom_range(0, 9) < 5));
        end
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised elastic buffer that sits between any two pipeline stages (if->id, id->ex, ex->wb) in place of a single valid/ready register slice.
- Holds up to DEPTH in-flight payloads in order, using a valid/ready handshake on both sides.
- Adds a pipeline-flush kill and an occupancy output; a single-entry slice has neither.
- Timing: in_ready_o never depends combinationally on out_ready_i.

Parameters:
- DATA_W, 64, payload width in bits (any struct such as ifToId_t or exToWb_t, flattened).
- DEPTH, 2, number of entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous active-high reset.
- flush_i  input  1  kill all held entries and any same-cycle push.
- in_valid_i  input  1  upstream payload valid.
- in_ready_o  output  1  buffer can accept a payload.
- in_data_i  input  DATA_W  upstream payload.
- out_valid_o  output  1  head entry valid.
- out_ready_i  input  1  downstream accepts the head entry.
- out_data_o  output  DATA_W  head entry payload.
- count_o  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x DATA_W array, plus wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register of CNT_W bits.
- Reset (rst_i=1 at an edge): wr_ptr=0, rd_ptr=0, count=0. Array contents are not reset.
- Outputs during and after reset: out_valid_o=0, in_ready_o=1, count_o=0. out_data_o is don't-care while out_valid_o=0.
- rst_i has priority over flush_i and over any handshake.
- push = in_valid_i & in_ready_o & ~flush_i.
- pop = out_valid_o & out_ready_i.
- in_ready_o = (count != DEPTH). It is a pure function of registered state.
- When full, no push is accepted even if a pop occurs in the same cycle (no full pass-through).
- out_valid_o = (count != 0) & ~flush_i.
- out_data_o = mem[rd_ptr], read combinationally from registered state.
- Latency: a payload pushed at edge N is visible on out_* from cycle N+1. There is no zero-cycle bypass, even when empty.
- push only: mem[wr_ptr] <= in_data_i, wr_ptr+1, count+1.
- pop only: rd_ptr+1, count-1.
- push and pop together (1 <= count <= DEPTH-1): both pointers advance and count is unchanged.
- push and pop together with count=1: the head is consumed and the new entry becomes the head next cycle, so out_valid_o stays 1.
- flush_i=1 (no reset):
  - next state: wr_ptr=rd_ptr=0, count=0;
  - the same-cycle push is dropped;
  - out_valid_o is gated to 0 in the flush cycle, so no pop occurs;
  - in_ready_o is still reported from the current count (upstream may see a handshake that is discarded).
- Back-to-back flushes: the buffer stays empty. The first push after flush deasserts is accepted normally.
- Ordering: strict FIFO. Payloads are never reordered, duplicated or lost except by flush_i.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble cycle.
- count_o = count register.
- Assertions (simulation only):
  - count <= DEPTH;
  - no write while count==DEPTH;
  - out_data_o is stable while out_valid_o & ~out_ready_i & ~flush_i.

Test Plan:
- Reset then idle, DEPTH=2: hold rst_i 2 cycles -> out_valid_o=0, in_ready_o=1, count_o=0. Release with in_valid_i=0 -> all three unchanged.
- Fill/drain, DEPTH=4, out_ready_i=0: push 0xA0,0xA1,0xA2,0xA3 on consecutive cycles -> count_o steps 1,2,3,4; in_ready_o=0 after the 4th push; a 5th push of 0xA4 is refused. Then raise out_ready_i -> outputs 0xA0..0xA3 in order, count_o back to 0.
- Wrap and streaming, DEPTH=4: 20 back-to-back pushes with out_ready_i=1 -> count_o holds at 1 after the first cycle; out_data_o sequence equals the input sequence, with each value one cycle late; pointers wrap 5 times with no bubble.
- Full plus pop, DEPTH=2: buffer full (0x11,0x22), in_valid_i=1 with 0x33, out_ready_i=1 -> 0x11 popped, 0x33 not accepted this cycle, count_o=1. 0x33 is accepted the next cycle.
- Flush mid-stream, DEPTH=4: count_o=3, then flush_i=1 with in_valid_i=1 and out_ready_i=1 for one cycle -> out_valid_o=0 in that cycle; next cycle count_o=0 and out_valid_o=0. A push of 0x55 the following cycle appears as the next head.
- Reset over flush: count_o=2, rst_i=1 and flush_i=1 together with in_valid_i=1 -> next cycle count_o=0, in_ready_o=1, and nothing is emitted.
